// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   CLKS_PER_BIT_DEFAULT : clk cycles per bit (25 MHz / 115200 baud)
//   DATA_BITS            : payload bits per 8N1 frame
//   uart_state_e         : serial FSM state encoding
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset : clock and synchronous active-high reset (pointers/count only)
//   wr, wdata  : push request and data
//   wr_ok      : high when the push in this cycle is accepted
//   rd         : pop request, ignored while empty
//   rdata      : head entry, valid while empty = 0
//   empty/full : occupancy flags
//   count      : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wr_ok,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic do_pop;
  logic do_push;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_COUNT);
  assign count  = count_q;
  assign rdata  = mem[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_pop  = rd && !empty;
  assign do_push = wr && (!full || do_pop);
  assign wr_ok   = do_push;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver feeding a receive FIFO.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   uart_in      : asynchronous serial line, idle high
//   rd           : one-cycle pop request
//   q            : FIFO head byte (first-word-fall-through), valid while empty = 0
//   empty, count : FIFO occupancy
//   frame_err    : sticky, a stop bit was sampled low
//   overflow     : sticky, a received byte was dropped because the FIFO was full
//   clr_err      : clears both sticky flags (a simultaneous new error wins)
//   rx_interrupt : one-cycle pulse in the cycle a byte is written into the FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_in,
  input  logic                   rd,
  output logic [7:0]             q,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overflow,
  input  logic                   clr_err,
  output logic                   rx_interrupt
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic line_prev_q, line_prev_d;
  logic line;

  uart_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           frame_err_q, frame_err_d;
  logic           overflow_q, overflow_d;

  logic push_req;
  logic frame_set;
  logic push_ok;
  logic fifo_full;

  assign line = sync2_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_comb begin
    sync1_d     = uart_in;
    sync2_d     = sync1_q;
    line_prev_d = sync2_q;
  end

  // Deserializer: START waits half a bit to land mid-bit, then every sample
  // after that is one full bit period later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!line && line_prev_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!line) begin
            state_d   = DATA;
            cnt_d     = BIT_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (line) push_req  = 1'b1;
          else      frame_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: clear first, so a coincident new error overrides clr_err.
  always_comb begin
    frame_err_d = clr_err ? 1'b0 : frame_err_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    if (frame_set)            frame_err_d = 1'b1;
    if (push_req && !push_ok) overflow_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push_req),
    .wdata (shift_q),
    .wr_ok (push_ok),
    .rd    (rd),
    .rdata (q),
    .empty (empty),
    .full  (fifo_full),
    .count (count)
  );

  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;
  assign rx_interrupt = push_ok;

endmodule
